uart_bram_writer: RTL and testbench

- UART 8N1 receiver that writes each received byte into a block RAM write port at an auto-incrementing address.
- Write-side counterpart to the BRAM-reader/UART-transmitter path in the top-level dut.
- Sits between the `rx` pin and port A of the BRAM, so a host can load memory contents over serial.

---
 rtl/uart_bram_writer.sv | 153 +++++++++++++++
 tb/tb_uart_bram_writer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bram_writer.sv
// UART receiver that stores each good byte into a BRAM write port at an auto-incrementing address.
// Define UART_PARITY_EN to receive 8E1 frames instead of 8N1.
module uart_bram_writer #(
    parameter int CLKS_PER_BIT = 278,
    parameter int ADDR_W       = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              addr_clr,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              busy,
    output logic              frame_err,
    output logic              wrapped
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, WRITE, WAIT_HIGH
    } state_t;

    state_t            state;
    logic              rx_meta, rx_s;
    logic [CW-1:0]     baud;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [ADDR_W-1:0] ptr;
`ifdef UART_PARITY_EN
    logic              parity_bad;
`endif

    assign bram_addr = ptr;
    assign busy      = (state != IDLE);

    // Idle-high reset keeps the receiver from seeing a false start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            bram_we    <= 1'b0;
            bram_din   <= '0;
            frame_err  <= 1'b0;
            ptr        <= '0;
            wrapped    <= 1'b0;
`ifdef UART_PARITY_EN
            parity_bad <= 1'b0;
`endif
        end else begin
            bram_we   <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        baud  <= '0;
                    end
                end
                START: begin
                    if (baud == HALF_END) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud == BIT_END) begin
                        baud    <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (baud == BIT_END) begin
                        baud       <= '0;
                        parity_bad <= ^{shreg, rx_s};
                        state      <= STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud == BIT_END) begin
                        baud <= '0;
`ifdef UART_PARITY_EN
                        if (parity_bad) begin
                            frame_err <= 1'b1;
                            state     <= rx_s ? IDLE : WAIT_HIGH;
                        end else
`endif
                        if (rx_s) begin
                            state    <= WRITE;
                            bram_we  <= 1'b1;
                            bram_din <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= WAIT_HIGH;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                WAIT_HIGH: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Clear beats the post-write increment; the write itself already used the old pointer.
            if (addr_clr) begin
                ptr     <= '0;
                wrapped <= 1'b0;
            end else if (state == WRITE) begin
                ptr <= ptr + 1'b1;
                if (ptr == '1) wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_bram_writer.sv
// Directed bench for uart_bram_writer: serial frames in, checked BRAM writes and error pulses out.
module tb_uart_bram_writer;

    localparam int CPB   = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT = 2 + CPB / 2 + (9 + PAR) * CPB + 1;

    logic          clk, rst, rx, addr_clr;
    logic          bram_we, busy, frame_err, wrapped;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;

    uart_bram_writer #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx), .addr_clr(addr_clr),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .busy(busy), .frame_err(frame_err), .wrapped(wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: bytes still owed to memory, errors still owed, and where the next write must land.
    logic [7:0]    exp_q[$];
    int            exp_err = 0;
    int            model_ptr = 0;
    logic          model_wrapped = 1'b0;
    int            we_count = 0;
    int            err_seen = 0;
    int            last_we_cyc = 0;
    logic [7:0]    last_din = '0;
    logic [AW-1:0] last_addr = '0;
    int            t_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bram_we) begin
                if (exp_q.size() == 0) begin
                    flag_fail("unexpected_write");
                end else begin
                    check("wr_data", bram_din, exp_q.pop_front());
                    check("wr_addr", bram_addr, model_ptr);
                    check("wrapped_at_write", wrapped, model_wrapped);
                end
                we_count++;
                last_we_cyc = cyc;
                last_din    = bram_din;
                last_addr   = bram_addr;
                model_ptr   = (model_ptr + 1) % DEPTH;
                if (model_ptr == 0) model_wrapped = 1'b1;
            end
            if (frame_err) begin
                err_seen++;
                if (exp_err == 0) flag_fail("unexpected_frame_err");
                else exp_err--;
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic good;
        good = stop_b && ((PAR == 0) || ((^d ^ par_b) == 1'b0));
        if (good) exp_q.push_back(d);
        else exp_err++;
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_PARITY_EN
        drive_bit(par_b);
`endif
        drive_bit(stop_b);
    endtask

    task automatic send(input logic [7:0] d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        rx = 1'b1;
        addr_clr = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.delete();
        exp_err = 0;
        model_ptr = 0;
        model_wrapped = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin : main
        int e0, w0, t0, ts;
        logic found;

        apply_reset();
        @(negedge clk);
        check("rst_we", bram_we, 0);
        check("rst_addr", bram_addr, 0);
        check("rst_din", bram_din, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_wrapped", wrapped, 0);
        @(posedge clk); #1;

        // Single byte with exact latency.
        send(8'hA5);
        ts = t_start;
        idle(2 * CPB);
        check("a5_count", we_count, 1);
        check("a5_latency", last_we_cyc - ts, LAT);
        check("a5_data", last_din, 8'hA5);
        check("a5_addr", last_addr, 0);
        @(negedge clk);
        check("a5_busy_after", busy, 0);
        @(posedge clk); #1;

        // Back-to-back frames, no idle gap.
        apply_reset();
        w0 = we_count; e0 = err_seen;
        send(8'h01); send(8'h02); send(8'h03);
        idle(2 * CPB);
        check("b2b_count", we_count - w0, 3);
        check("b2b_last_addr", last_addr, 2);
        check("b2b_last_data", last_din, 8'h03);
        check("b2b_no_err", err_seen - e0, 0);

        // Pointer wrap, then addr_clr.
        apply_reset();
        for (int i = 0; i < 15; i++) send(8'(i));
        idle(2 * CPB);
        @(negedge clk);
        check("wrap_before", wrapped, 0);
        @(posedge clk); #1;
        send(8'h0F);
        idle(2 * CPB);
        @(negedge clk);
        check("wrap_after16", wrapped, 1);
        check("wrap_ptr0", bram_addr, 0);
        @(posedge clk); #1;
        send(8'h55);
        idle(2 * CPB);
        check("wrap_55_addr", last_addr, 0);
        check("wrap_55_data", last_din, 8'h55);
        addr_clr = 1'b1;
        @(posedge clk); #1;
        addr_clr = 1'b0;
        model_ptr = 0;
        model_wrapped = 1'b0;
        @(negedge clk);
        check("clr_wrapped", wrapped, 0);
        check("clr_ptr", bram_addr, 0);
        @(posedge clk); #1;

        // addr_clr coincident with the write cycle.
        send(8'h22);
        idle(CPB);
        fork
            send(8'h11);
            begin
                found = 1'b0;
                for (int k = 0; k < LAT + 20 && !found; k++) begin
                    @(negedge clk);
                    if (bram_we) found = 1'b1;
                end
                if (found) begin
                    addr_clr = 1'b1;
                    @(posedge clk); #1;
                    addr_clr = 1'b0;
                    model_ptr = 0;
                    model_wrapped = 1'b0;
                end else begin
                    flag_fail("clr_we_timeout");
                end
            end
        join
        idle(2 * CPB);
        check("clr_wr_old_addr", last_addr, 1);
        check("clr_wr_data", last_din, 8'h11);
        @(negedge clk);
        check("clr_wr_ptr0", bram_addr, 0);
        @(posedge clk); #1;

        // Bad stop bit followed by a long break.
        apply_reset();
        e0 = err_seen; w0 = we_count;
        send_frame(8'h3C, 1'b0, ^8'h3C);
        repeat (40 * CPB) @(posedge clk);
        #1 rx = 1'b1;
        idle(2 * CPB);
        check("break_one_err", err_seen - e0, 1);
        check("break_no_write", we_count - w0, 0);
        send(8'h77);
        idle(2 * CPB);
        check("break_77_addr", last_addr, 0);
        check("break_77_data", last_din, 8'h77);

        // Short glitch on an idle line.
        apply_reset();
        e0 = err_seen; w0 = we_count;
        t0 = cyc;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", busy, 1);
        for (int k = 0; k < CPB / 2 - 2; k++) @(negedge clk);
        check("glitch_busy_before_end", busy, 1);
        @(negedge clk);
        check("glitch_busy_window", cyc - t0, CPB / 2 + 3);
        check("glitch_busy_lo", busy, 0);
        idle(2 * CPB);
        check("glitch_no_write", we_count - w0, 0);
        check("glitch_no_err", err_seen - e0, 0);

        // Reset in the middle of a frame.
        apply_reset();
        send(8'h9A);
        idle(CPB);
        w0 = we_count;
        drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        @(negedge clk);
        check("midrst_busy_pre", busy, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_addr", bram_addr, 0);
        check("midrst_din", bram_din, 0);
        check("midrst_we", bram_we, 0);
        exp_q.delete();
        exp_err = 0;
        model_ptr = 0;
        model_wrapped = 1'b0;
        @(posedge clk); #1;
        rx = 1'b1;
        rst = 1'b0;
        idle(12 * CPB);
        check("midrst_no_write", we_count - w0, 0);
        send(8'h5A);
        idle(2 * CPB);
        check("midrst_next_addr", last_addr, 0);
        check("midrst_next_data", last_din, 8'h5A);

`ifdef UART_PARITY_EN
        // Parity error, then the same byte with good parity.
        apply_reset();
        e0 = err_seen; w0 = we_count;
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        idle(2 * CPB);
        check("par_err", err_seen - e0, 1);
        check("par_write", we_count - w0, 1);
        check("par_addr", last_addr, 0);
        check("par_data", last_din, 8'h03);
`endif

        check("exp_q_drained", exp_q.size(), 0);
        check("exp_err_drained", exp_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
